// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: result-select encodings, forwarding selects
// and the MUL/DIV sequencer state type.
package riscv_pkg;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

endpackage

// File: rtl/md_seq.sv
// MUL/DIV sequencer: holds the instruction in E for MD_LAT cycles and
// flags the final cycle with a one-cycle done pulse.
module md_seq
  import riscv_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic mdStall_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MD_LAT > 2) ? (MD_LAT - 3) : 0);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start and BUSY cycles stall; the DONE cycle lets E advance, and start is
  // ignored there because it still belongs to the departing instruction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdStall_o = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mdStall_o = 1'b1;
          if (MD_LAT == 2) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        mdStall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E-stage forwarding, load-use stall, branch
// flush and MUL/DIV sequencing for the F/D/E/M/W stage registers.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [2:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdBusy,
  output logic              MdDone
);

  logic mdStall;
  logic loadUse;
  logic branchFlush;

  md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (MdStartE),
    .mdStall_o(mdStall),
    .busy_o   (MdBusy),
    .done_o   (MdDone)
  );

  // M is the younger producer, so it wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = FWD_W;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = FWD_W;
  end

  assign loadUse = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // A held MUL/DIV instruction in E cannot be a branch.
  assign branchFlush = PCSrcE & ~mdStall;

  assign StallF = loadUse | mdStall;
  assign StallD = loadUse | mdStall;
  assign StallE = mdStall;
  assign FlushD = branchFlush;
  assign FlushE = loadUse | branchFlush;
  assign FlushM = mdStall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl at MD_LAT = 4, 2 and 32,
// compared against a cycle-position reference model.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MdStartE;
  logic [2:0] ResultSrcE;

  logic       sF [3], sD [3], sE [3], fD [3], fE [3], fM [3], busy [3], done [3];
  logic [1:0] fa [3], fb [3];

  int lat [3] = '{4, 2, 32};
  int mpos [3] = '{-1, -1, -1};
  int total = 0;
  int bad = 0;

  hazard_ctrl #(.MD_LAT(4), .REG_AW(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .StallF(sF[0]), .StallD(sD[0]), .StallE(sE[0]), .FlushD(fD[0]), .FlushE(fE[0]),
    .FlushM(fM[0]), .ForwardAE(fa[0]), .ForwardBE(fb[0]), .MdBusy(busy[0]), .MdDone(done[0]));

  hazard_ctrl #(.MD_LAT(2), .REG_AW(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .StallF(sF[1]), .StallD(sD[1]), .StallE(sE[1]), .FlushD(fD[1]), .FlushE(fE[1]),
    .FlushM(fM[1]), .ForwardAE(fa[1]), .ForwardBE(fb[1]), .MdBusy(busy[1]), .MdDone(done[1]));

  hazard_ctrl #(.MD_LAT(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .StallF(sF[2]), .StallD(sD[2]), .StallE(sE[2]), .FlushD(fD[2]), .FlushE(fE[2]),
    .FlushM(fM[2]), .ForwardAE(fa[2]), .ForwardBE(fb[2]), .MdBusy(busy[2]), .MdDone(done[2]));

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // mpos is the cycle index of the MUL/DIV op occupying E (-1 when none).
  task automatic checkAll(input string tag);
    logic ms, dn, bsy, lw, br;
    logic [15:0] act, exp;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) mpos[i] = -1;
      bsy = (mpos[i] >= 0);
      ms  = bsy ? (mpos[i] < lat[i] - 1) : MdStartE;
      dn  = bsy && (mpos[i] == lat[i] - 1);
      lw  = (ResultSrcE == 3'b001) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
      br  = PCSrcE;
      exp = {4'b0, lw | ms, lw | ms, ms, br, lw | br, ms,
             fwdModel(Rs1E), fwdModel(Rs2E), bsy, dn};
      act = {4'b0, sF[i], sD[i], sE[i], fD[i], fE[i], fM[i], fa[i], fb[i], busy[i], done[i]};
      checkOutput($sformatf("%s/lat%0d", tag, lat[i]), act, exp);
      if (rst_n) begin
        if (mpos[i] < 0) begin
          if (MdStartE) mpos[i] = 1;
        end else begin
          mpos[i]++;
          if (mpos[i] == lat[i]) mpos[i] = -1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag,
                               input logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw,
                               input logic rwm, rww, input logic [2:0] rsrc,
                               input logic pc, st);
    @(negedge clk);
    Rs1D = r1d; Rs2D = r2d; Rs1E = r1e; Rs2E = r2e;
    RdE = rde; RdM = rdm; RdW = rdw;
    RegWriteM = rwm; RegWriteW = rww; ResultSrcE = rsrc;
    PCSrcE = pc; MdStartE = st;
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MdStartE} = '0;
    ResultSrcE = 3'b000;
    applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    checkOutput("resetBusy", {15'b0, busy[2]}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    applyStimulus("fwdMW", 0, 0, 5, 6, 0, 5, 5, 1, 1, 3'b000, 0, 0);
    checkOutput("fwdA_M", {14'b0, fa[0]}, 16'h2);
    checkOutput("fwdB_RF", {14'b0, fb[0]}, 16'h0);
    applyStimulus("fwdW", 0, 0, 5, 6, 0, 5, 5, 0, 1, 3'b000, 0, 0);
    checkOutput("fwdA_W", {14'b0, fa[0]}, 16'h1);
    applyStimulus("fwdX0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0);
    checkOutput("fwdX0A", {14'b0, fa[0]}, 16'h0);

    applyStimulus("loadUse", 0, 7, 0, 0, 7, 0, 0, 0, 0, 3'b001, 0, 0);
    checkOutput("luStall", {13'b0, sF[0], sE[0], fE[0]}, 16'h5);
    applyStimulus("loadX0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0);
    applyStimulus("branch", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    checkOutput("brFlush", {13'b0, fD[0], fE[0], sF[0]}, 16'h6);
    idleCycles(1);

    // MdStartE held from cycle 0; dut4 shows the 4-cycle shape, dut2 the 2-cycle.
    for (int c = 0; c < 6; c++)
      applyStimulus($sformatf("mdHold%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
    idleCycles(40);

    for (int c = 0; c < 5; c++)
      applyStimulus($sformatf("mdRun%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, c == 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", {15'b0, busy[2]}, 16'h0);
    checkAll("midRst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++)
      applyStimulus("postRst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

    // Pipeline hazards only, sequencers idle.
    for (int c = 0; c < 300; c++)
      applyStimulus("randHaz", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    3'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 0);

    // MUL/DIV traffic with forwarding still active; no loads or branches.
    for (int c = 0; c < 400; c++)
      applyStimulus("randMd", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    3'($urandom_range(0, 1)) << 1, 0, 1'($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W). Drives forwarding selects into the E-stage ALU muxes, load-use stalls, and branch/jump flushes. Sequences an iterative multi-cycle MUL/DIV unit in E by holding F/D/E and inserting bubbles into M until the unit finishes. Sits beside the stage registers and drives their enable and clear inputs.

Parameters:
MD_LAT, 32, total cycles a MUL/DIV instruction occupies E, including the start cycle and the done cycle; legal values >= 2.
REG_AW, 5, register-index width.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
Rs1D  in  REG_AW  rs1 of instruction in D
Rs2D  in  REG_AW  rs2 of instruction in D
Rs1E  in  REG_AW  rs1 of instruction in E
Rs2E  in  REG_AW  rs2 of instruction in E
RdE  in  REG_AW  rd of instruction in E
RdM  in  REG_AW  rd of instruction in M
RdW  in  REG_AW  rd of instruction in W
RegWriteM  in  1  M instruction writes rd
RegWriteW  in  1  W instruction writes rd
ResultSrcE  in  3  result select of E instruction; RESULT_SRC_LOAD marks a load
PCSrcE  in  1  taken branch or jump resolved in E
MdStartE  in  1  E holds a MUL/DIV instruction
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushM  out  1  clear E/M register (bubble)
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
MdBusy  out  1  MUL/DIV sequencer not idle
MdDone  out  1  one-cycle pulse: MUL/DIV result valid in E this cycle

Behaviour:
- Reset: state=IDLE, cnt=0. With all inputs low, every output is 0.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise 00. M has priority over W. ForwardBE is the same rule on Rs2E.
- Load-use: lw = (ResultSrcE==RESULT_SRC_LOAD) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
  - lw gives StallF=StallD=1 and FlushE=1 for that cycle.
- Branch: PCSrcE gives FlushD=1 and FlushE=1.
- FlushE = lw | PCSrcE. Stall and flush are independent ORs.
- MUL/DIV FSM, states IDLE, BUSY, DONE; cnt width $clog2(MD_LAT):
  - IDLE with MdStartE: stall this cycle (combinational). If MD_LAT==2, go to DONE; otherwise go to BUSY with cnt=MD_LAT-3.
  - BUSY: stall. If cnt==0, go to DONE; otherwise cnt--.
  - DONE: no MUL/DIV stall. MdDone=1 and E advances. Go to IDLE. MdStartE is ignored here because it still refers to the departing instruction.
  - mdstall = (IDLE and MdStartE) or BUSY. mdstall gives StallF=StallD=StallE=1 and FlushM=1.
  - MdBusy = (state!=IDLE).
- Result: E is occupied for exactly MD_LAT cycles, and M receives exactly MD_LAT-1 bubbles.
- PCSrcE and lw cannot coincide with mdstall, because E holds the MUL/DIV instruction. During BUSY, PCSrcE is ignored for flushes.
- Forwarding keeps evaluating during BUSY.
- Reset mid-operation: rst_n low forces IDLE and cnt=0 immediately. No MdDone pulse is produced.

Decomposition:
- Shared package riscv_pkg holds:
  - RESULT_SRC_LOAD=3'b001
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - md_state_t enum {IDLE, BUSY, DONE}
- One sub-module, md_seq (FSM plus counter; outputs mdstall, MdBusy, MdDone).
- Forwarding, load-use and flush logic stay combinational in the top.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- RdM=0, RegWriteM=1, Rs1E=0 -> ForwardAE=00 (x0 never forwarded).
- ResultSrcE=001, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallE=0. Same with RdE=0 -> all 0.
- PCSrcE=1 for one cycle -> FlushD=FlushE=1, no stalls.
- MD_LAT=4, MdStartE held high from cycle 0:
  - Cycles 0-2: StallF/D/E=1, FlushM=1, MdBusy=0,1,1.
  - Cycle 3: MdDone=1, stalls 0.
  - Cycle 4: IDLE.
  - Repeat with MD_LAT=2 -> one stall cycle, then MdDone.
- MD_LAT=32, rst_n pulsed low in cycle 5 of a MUL/DIV -> MdBusy=0 immediately. After release with MdStartE=0, no stall and no MdDone.
